coffee_vend_ctrl: RTL and testbench
===================================

// Module: coffee_vend_ctrl
// PURPOSE
//  Top-level sequencer for the coffee vending datapath: latches a drink selection, accumulates
//  coins against that drink's price, drives the dispenser handshake, then returns change/refund.
//  Sits between the front panel (coin slot, select buttons, cancel) and the dispenser/change units.
// PARAMETERS
//  SUM_W          5     width of coin accumulator and change amount (max held sum 19 must fit)
//  PRICE_FILTER   2     price of selection 2'b00 (Rs)
//  PRICE_BLACK    1     price of selection 2'b01
//  PRICE_BRU      5     price of selection 2'b10
//  PRICE_NESCAFE  10    price of selection 2'b11
//  TIMEOUT_CYCLES 1000  COLLECT inactivity limit (used only with VEND_TIMEOUT_EN)
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  rst          in   1      asynchronous, active-low reset
//  sel_valid    in   1      one-cycle pulse: coffee_sel valid
//  coffee_sel   in   2      drink code (encoding above)
//  coin_valid   in   1      one-cycle pulse: coin_val valid
//  coin_val     in   4      coin value in Rs; legal values 1,2,5,10 only
//  cancel       in   1      user cancel request (level, sampled each cycle)
//  disp_req     out  1      dispense request, held until disp_done
//  disp_type    out  2      latched drink code, stable while disp_req=1
//  disp_done    in   1      one-cycle pulse from dispenser: cup complete
//  change_valid out  1      change/refund amount valid, held until change_ack
//  change_amt   out  SUM_W  Rs to return, stable while change_valid=1
//  change_ack   in   1      change unit accepted amount
//  coin_reject  out  1      one-cycle pulse: last coin not accepted (return it)
//  LED_Green    out  1      machine ready (IDLE)
//  LED_Yellow   out  1      transaction in progress (any non-IDLE state)
// BEHAVIOUR
//  All outputs registered. Reset (rst=0, async): state=IDLE, sum=0, disp_req=0, disp_type=0,
//   change_valid=0, change_amt=0, coin_reject=0, LED_Green=1, LED_Yellow=0. Reset mid-transaction
//   abandons it; no refund issued.
//  IDLE: sel_valid -> latch coffee_sel, price; sum=0; -> COLLECT. coin_valid -> coin_reject pulse.
//  COLLECT: legal coin adds to sum; illegal coin_val -> coin_reject, sum unchanged.
//   next_sum >= price -> DISPENSE on same edge (disp_req=1 cycle after the completing coin).
//   cancel=1 -> CHANGE with change_amt=next_sum if next_sum>0, else IDLE. cancel beats completion
//   when both occur same cycle (coin included in refund). sel_valid ignored.
//  DISPENSE: disp_req=1, disp_type=latched code; coins rejected; cancel ignored.
//   disp_done -> CHANGE with change_amt=sum-price if sum>price, else IDLE; disp_req drops same edge.
//  CHANGE: change_valid=1; coins rejected; cancel, sel_valid ignored. change_ack -> IDLE, sum=0.
//   change_ack while change_valid=0 ignored.
//  Arithmetic: unsigned SUM_W-bit; sum never exceeds price-1+10, no overflow path; change = sum-price.
//  LED_Green=1 iff state==IDLE; LED_Yellow=1 otherwise (registered with state).
//  coin_reject asserted exactly one cycle after each rejected coin_valid; never held.
// CONFIGURATION
//  VEND_TIMEOUT_EN defined: 16-bit inactivity counter runs in COLLECT, cleared on entry and on every
//   accepted coin; reaching TIMEOUT_CYCLES acts as cancel (refund sum if >0, else IDLE).
//  VEND_TIMEOUT_EN undefined: no counter; COLLECT waits indefinitely; TIMEOUT_CYCLES unused.
// TESTING
//  Reset: rst=0 mid-DISPENSE -> all outputs at reset values, LED_Green=1 same cycle (async).
//  sel=11, coins 5,5 -> disp_req=1 cycle after 2nd coin, disp_type=11; disp_done -> IDLE, no change.
//  sel=00, coin 10 -> DISPENSE; disp_done -> change_valid=1, change_amt=8; change_ack -> IDLE.
//  sel=10, coin 3 -> coin_reject pulse, sum=0; coin 2 then cancel -> change_amt=2; coin in IDLE rejected.
//  sel=10, coin 2, then coin 5 with cancel same cycle -> no disp_req; change_amt=7.
//  VEND_TIMEOUT_EN, TIMEOUT_CYCLES=20: sel=01, no coins -> IDLE after 20 cycles, change_valid never 1.

Source files
------------

// File: rtl/coffee_vend_ctrl.sv
// Coffee vending sequencer: selection latch, coin accumulation, dispense and change handshakes.
// Optional COLLECT inactivity timeout is compiled in when VEND_TIMEOUT_EN is defined.
module coffee_vend_ctrl #(
    parameter int SUM_W          = 5,
    parameter int PRICE_FILTER   = 2,
    parameter int PRICE_BLACK    = 1,
    parameter int PRICE_BRU      = 5,
    parameter int PRICE_NESCAFE  = 10,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel_valid,
    input  logic [1:0]       coffee_sel,
    input  logic             coin_valid,
    input  logic [3:0]       coin_val,
    input  logic             cancel,
    output logic             disp_req,
    output logic [1:0]       disp_type,
    input  logic             disp_done,
    output logic             change_valid,
    output logic [SUM_W-1:0] change_amt,
    input  logic             change_ack,
    output logic             coin_reject,
    output logic             LED_Green,
    output logic             LED_Yellow
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    state_t           state_q;
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] price_q;
    logic [1:0]       disp_type_q;
    logic             disp_req_q;
    logic             change_valid_q;
    logic [SUM_W-1:0] change_amt_q;
    logic             coin_reject_q;
    logic             led_green_q;
    logic             led_yellow_q;

    logic             coin_legal;
    logic             coin_take;
    logic             coin_rej;
    logic [SUM_W-1:0] next_sum;
    logic             timeout_hit;

    function automatic logic [SUM_W-1:0] price_of(input logic [1:0] code);
        case (code)
            2'b00:   return SUM_W'(PRICE_FILTER);
            2'b01:   return SUM_W'(PRICE_BLACK);
            2'b10:   return SUM_W'(PRICE_BRU);
            default: return SUM_W'(PRICE_NESCAFE);
        endcase
    endfunction

    assign coin_legal = (coin_val == 4'd1) || (coin_val == 4'd2) ||
                        (coin_val == 4'd5) || (coin_val == 4'd10);
    assign coin_take  = coin_valid && coin_legal && (state_q == S_COLLECT);
    assign coin_rej   = coin_valid && !coin_take;
    assign next_sum   = sum_q + (coin_take ? SUM_W'(coin_val) : '0);

`ifdef VEND_TIMEOUT_EN
    logic [15:0] idle_cnt_q;

    // Counter is zero on COLLECT entry because every other state holds it cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt_q <= '0;
        end else if (state_q != S_COLLECT || coin_take) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 16'd1;
        end
    end

    assign timeout_hit = (state_q == S_COLLECT) && !coin_take &&
                         (idle_cnt_q >= 16'(TIMEOUT_CYCLES - 1));
`else
    // No timer in this build: the expression is constant false.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        state_t state_d;
        if (!rst) begin
            state_q        <= S_IDLE;
            sum_q          <= '0;
            price_q        <= '0;
            disp_type_q    <= 2'b00;
            disp_req_q     <= 1'b0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            coin_reject_q  <= 1'b0;
            led_green_q    <= 1'b1;
            led_yellow_q   <= 1'b0;
        end else begin
            state_d       = state_q;
            coin_reject_q <= coin_rej;
            case (state_q)
                S_IDLE: begin
                    if (sel_valid) begin
                        disp_type_q <= coffee_sel;
                        price_q     <= price_of(coffee_sel);
                        sum_q       <= '0;
                        state_d     = S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    sum_q <= next_sum;
                    // Cancel wins over a completing coin; that coin is part of the refund.
                    if (cancel || timeout_hit) begin
                        if (next_sum != '0) begin
                            change_amt_q   <= next_sum;
                            change_valid_q <= 1'b1;
                            state_d        = S_CHANGE;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (next_sum >= price_q) begin
                        disp_req_q <= 1'b1;
                        state_d    = S_DISPENSE;
                    end
                end
                S_DISPENSE: begin
                    if (disp_done) begin
                        disp_req_q <= 1'b0;
                        if (sum_q > price_q) begin
                            change_amt_q   <= sum_q - price_q;
                            change_valid_q <= 1'b1;
                            state_d        = S_CHANGE;
                        end else begin
                            sum_q   <= '0;
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    if (change_ack) begin
                        change_valid_q <= 1'b0;
                        sum_q          <= '0;
                        state_d        = S_IDLE;
                    end
                end
            endcase
            state_q      <= state_d;
            led_green_q  <= (state_d == S_IDLE);
            led_yellow_q <= (state_d != S_IDLE);
        end
    end

    assign disp_req     = disp_req_q;
    assign disp_type    = disp_type_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign coin_reject  = coin_reject_q;
    assign LED_Green    = led_green_q;
    assign LED_Yellow   = led_yellow_q;

endmodule

// File: tb/tb_coffee_vend_ctrl.sv
// Directed bench for coffee_vend_ctrl: output events are matched against a queue of expected events.
module tb_coffee_vend_ctrl;

    localparam int K_DISP = 100;
    localparam int K_CHG  = 200;
    localparam int K_REJ  = 300;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel_valid, coin_valid, cancel, disp_done, change_ack;
    logic [1:0] coffee_sel;
    logic [3:0] coin_val;
    logic       disp_req, change_valid, coin_reject, LED_Green, LED_Yellow;
    logic [1:0] disp_type;
    logic [4:0] change_amt;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    coffee_vend_ctrl #(.SUM_W(5), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst(rst), .sel_valid(sel_valid), .coffee_sel(coffee_sel),
        .coin_valid(coin_valid), .coin_val(coin_val), .cancel(cancel),
        .disp_req(disp_req), .disp_type(disp_type), .disp_done(disp_done),
        .change_valid(change_valid), .change_amt(change_amt), .change_ack(change_ack),
        .coin_reject(coin_reject), .LED_Green(LED_Green), .LED_Yellow(LED_Yellow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input int obs);
        if (exp_q.size() == 0) chk("sb_unexpected_event", obs, 0);
        else                   chk("sb_event", obs, exp_q.pop_front());
    endtask

    // Output event monitor: rising disp_req, rising change_valid, each coin_reject pulse.
    logic pr_disp, pr_chg;
    always @(negedge clk) begin
        if (!rst) begin
            pr_disp = 1'b0;
            pr_chg  = 1'b0;
        end else begin
            if (disp_req && !pr_disp)    sb_pop(K_DISP + int'(disp_type));
            if (change_valid && !pr_chg) sb_pop(K_CHG + int'(change_amt));
            if (coin_reject)             sb_pop(K_REJ);
            pr_disp = disp_req;
            pr_chg  = change_valid;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_sel(input logic [1:0] c);
        sel_valid = 1'b1; coffee_sel = c; tick(); sel_valid = 1'b0;
    endtask

    task automatic do_coin(input logic [3:0] v, input logic c = 1'b0);
        coin_valid = 1'b1; coin_val = v; cancel = c; tick();
        coin_valid = 1'b0; cancel = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1; tick(); cancel = 1'b0;
    endtask

    task automatic do_done();
        disp_done = 1'b1; tick(); disp_done = 1'b0;
    endtask

    task automatic do_ack();
        change_ack = 1'b1; tick(); change_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b0; sel_valid = 1'b0; coffee_sel = 2'b00; coin_valid = 1'b0; coin_val = 4'd0;
        cancel = 1'b0; disp_done = 1'b0; change_ack = 1'b0;
        tick(2);
        chk("rst_green", LED_Green, 1);
        chk("rst_yellow", LED_Yellow, 0);
        chk("rst_disp_req", disp_req, 0);
        chk("rst_disp_type", disp_type, 0);
        chk("rst_change_valid", change_valid, 0);
        chk("rst_change_amt", change_amt, 0);
        chk("rst_coin_reject", coin_reject, 0);
        rst = 1'b1;
        tick();

        // Nescafe paid exactly with 5+5; coin during dispense is rejected
        do_sel(2'b11);
        chk("t1_yellow", LED_Yellow, 1);
        chk("t1_green", LED_Green, 0);
        do_coin(4'd5);
        chk("t1_no_disp_yet", disp_req, 0);
        exp_q.push_back(K_DISP + 3);
        do_coin(4'd5);
        chk("t1_disp_req", disp_req, 1);
        chk("t1_disp_type", disp_type, 3);
        exp_q.push_back(K_REJ);
        do_coin(4'd2);
        chk("t1_rej_pulse", coin_reject, 1);
        tick();
        chk("t1_rej_cleared", coin_reject, 0);
        chk("t1_disp_held", disp_req, 1);
        do_done();
        chk("t1_disp_drop", disp_req, 0);
        chk("t1_idle", LED_Green, 1);
        chk("t1_no_change", change_valid, 0);

        // Filter with a 10 coin -> change 8, held until ack, cancel ignored in CHANGE
        do_sel(2'b00);
        exp_q.push_back(K_DISP + 0);
        do_coin(4'd10);
        chk("t2_disp_req", disp_req, 1);
        chk("t2_disp_type", disp_type, 0);
        exp_q.push_back(K_CHG + 8);
        do_done();
        chk("t2_change_valid", change_valid, 1);
        chk("t2_change_amt", change_amt, 8);
        chk("t2_disp_drop", disp_req, 0);
        do_cancel();
        tick();
        chk("t2_change_held", change_valid, 1);
        chk("t2_amt_held", change_amt, 8);
        do_ack();
        chk("t2_change_drop", change_valid, 0);
        chk("t2_idle", LED_Green, 1);

        // Bru: illegal coin rejected, coin 2 then cancel refunds 2, coin in IDLE rejected
        do_sel(2'b10);
        exp_q.push_back(K_REJ);
        do_coin(4'd3);
        chk("t3_rej_pulse", coin_reject, 1);
        do_coin(4'd2);
        chk("t3_rej_once", coin_reject, 0);
        chk("t3_no_disp", disp_req, 0);
        exp_q.push_back(K_CHG + 2);
        do_cancel();
        chk("t3_change_valid", change_valid, 1);
        chk("t3_change_amt", change_amt, 2);
        do_ack();
        exp_q.push_back(K_REJ);
        do_coin(4'd5);
        chk("t3_idle_rej", coin_reject, 1);
        chk("t3_idle_green", LED_Green, 1);

        // Completing coin with cancel in the same cycle -> refund 7, no dispense
        do_sel(2'b10);
        do_coin(4'd2);
        exp_q.push_back(K_CHG + 7);
        do_coin(4'd5, 1'b1);
        chk("t4_no_disp", disp_req, 0);
        chk("t4_change_valid", change_valid, 1);
        chk("t4_change_amt", change_amt, 7);
        do_ack();

        // Cancel with nothing inserted returns straight to IDLE
        do_sel(2'b01);
        do_cancel();
        chk("t5_idle", LED_Green, 1);
        chk("t5_no_change", change_valid, 0);

        // Reselect during COLLECT is ignored: price stays 10
        do_sel(2'b11);
        do_sel(2'b01);
        do_coin(4'd1);
        chk("t6_price_kept", disp_req, 0);
        exp_q.push_back(K_DISP + 3);
        do_coin(4'd10);
        chk("t6_disp_type", disp_type, 3);
        exp_q.push_back(K_CHG + 1);
        do_done();
        chk("t6_change_amt", change_amt, 1);
        do_ack();

        // Largest held sum: 9 then a 10 coin -> sum 19, change 9
        do_sel(2'b11);
        do_coin(4'd5);
        do_coin(4'd2);
        do_coin(4'd2);
        chk("t7_no_disp", disp_req, 0);
        exp_q.push_back(K_DISP + 3);
        do_coin(4'd10);
        exp_q.push_back(K_CHG + 9);
        do_done();
        chk("t7_change_amt", change_amt, 9);
        do_ack();

`ifdef VEND_TIMEOUT_EN
        do_sel(2'b01);
        tick(19);
        chk("t8_still_collect", LED_Yellow, 1);
        tick(1);
        chk("t8_timeout_idle", LED_Green, 1);
        chk("t8_no_change", change_valid, 0);
        do_sel(2'b10);
        tick(10);
        do_coin(4'd1);
        tick(19);
        chk("t8_coin_restart", LED_Yellow, 1);
        exp_q.push_back(K_CHG + 1);
        tick(1);
        chk("t8_timeout_refund", change_valid, 1);
        chk("t8_refund_amt", change_amt, 1);
        do_ack();
`else
        do_sel(2'b01);
        tick(40);
        chk("t8_waits", LED_Yellow, 1);
        do_cancel();
        chk("t8_cancel_idle", LED_Green, 1);
`endif

        // Asynchronous reset in the middle of a dispense
        do_sel(2'b11);
        exp_q.push_back(K_DISP + 3);
        do_coin(4'd10);
        chk("t9_disp_req", disp_req, 1);
        #2 rst = 1'b0;
        #1;
        chk("t9_async_green", LED_Green, 1);
        chk("t9_async_yellow", LED_Yellow, 0);
        chk("t9_async_disp_req", disp_req, 0);
        chk("t9_async_disp_type", disp_type, 0);
        chk("t9_async_change", change_valid, 0);
        tick(2);
        rst = 1'b1;
        tick();
        exp_q.push_back(K_REJ);
        do_coin(4'd2);
        chk("t9_idle_rej", coin_reject, 1);
        chk("t9_no_refund", change_valid, 0);

        tick(2);
        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
